// File: rtl/sh_r.sv
`default_nettype none
// ============================================================================
// Module   : sh_r
// Brief    : Multiplier-operand right-shift register for a shift-and-add
//            multiplier. Loads zero-extended portB while in reset and
//            shifts right by one (zero fill) once per rising edge of the
//            init_sh_r strobe. The LSB of sal_sh_r tells the controller
//            whether to add in the current iteration.
// Revision : 1.0 - initial release
// ============================================================================
module sh_r #(
    parameter int IN_W  = 3,
    parameter int OUT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  portB,
    input  logic             init_sh_r,
    output logic [OUT_W-1:0] sal_sh_r
);

    logic             r_init_q;
    logic [OUT_W-1:0] r_sh;
    logic [OUT_W-1:0] w_load;
    logic             w_shift_pulse;

    // Operand zero-extended to the register width
    generate
        if (OUT_W > IN_W) begin : g_zext
            assign w_load = {{(OUT_W-IN_W){1'b0}}, portB};
        end else begin : g_direct
            assign w_load = portB[OUT_W-1:0];
        end
    endgenerate

    // One pulse per low-to-high transition of the controller strobe
    assign w_shift_pulse = init_sh_r & ~r_init_q;

    // Previous strobe sample; keeps tracking through reset so a strobe held
    // high across reset release does not count as a fresh edge
    always_ff @(posedge clk) begin
        r_init_q <= init_sh_r;
    end

    // Operand register: load wins over shift, zero fill saturates at zero
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sh <= w_load;
        end else if (w_shift_pulse) begin
            r_sh <= r_sh >> 1;
        end
    end

    assign sal_sh_r = r_sh;

endmodule
`default_nettype wire

// File: tb/tb_sh_r.sv
`default_nettype none
// ============================================================================
// Module   : tb_sh_r
// Brief    : Self-checking bench for sh_r. A reference model tracks the
//            operand value as an integer: reload on reset, halve on each
//            newly observed high strobe sample.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/100ps
module tb_sh_r;

    logic       clk;
    logic       rst;
    logic [2:0] portB;
    logic       init_sh_r;
    logic [3:0] sal_sh_r;

    int n_err;
    int n_chk;

    // Reference model state
    int m_val;
    bit m_prev_high;

    sh_r #(.IN_W(3), .OUT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .portB     (portB),
        .init_sh_r (init_sh_r),
        .sal_sh_r  (sal_sh_r)
    );

    initial clk = 1'b0;
    always #1 clk = ~clk;

    // Advance one clock: model the edge, return at the following falling edge
    task automatic cycle();
        @(posedge clk);
        if (rst) begin
            m_val = int'(portB);
        end else if (init_sh_r && !m_prev_high) begin
            m_val = m_val / 2;
        end
        m_prev_high = init_sh_r;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; portB = 3'd5; init_sh_r = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            n_chk++;
            if (sal_sh_r !== 4'b0101) begin
                n_err++;
                $display("FAIL reset_load cyc=%0d got=%b exp=%b", i, sal_sh_r, 4'b0101);
            end
        end
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            n_chk++;
            if (sal_sh_r !== 4'b0101) begin
                n_err++;
                $display("FAIL reset_hold cyc=%0d got=%b exp=%b", i, sal_sh_r, 4'b0101);
            end
        end
    endtask

    task automatic test_single_shifts();
        logic [3:0] steps [4];
        steps[0] = 4'b0010; steps[1] = 4'b0001; steps[2] = 4'b0000; steps[3] = 4'b0000;
        for (int p = 0; p < 4; p++) begin
            init_sh_r = 1'b1;
            for (int c = 0; c < 5; c++) begin
                cycle();
                n_chk++;
                if (sal_sh_r !== steps[p] || int'(sal_sh_r) != m_val) begin
                    n_err++;
                    $display("FAIL single_shift p=%0d c=%0d got=%b exp=%b model=%0d", p, c, sal_sh_r, steps[p], m_val);
                end
            end
            init_sh_r = 1'b0;
            for (int c = 0; c < 20; c++) begin
                cycle();
                n_chk++;
                if (sal_sh_r !== steps[p]) begin
                    n_err++;
                    $display("FAIL single_gap p=%0d c=%0d got=%b exp=%b", p, c, sal_sh_r, steps[p]);
                end
            end
        end
    endtask

    task automatic load(input logic [2:0] b);
        rst = 1'b1; portB = b; init_sh_r = 1'b0;
        cycle();
        rst = 1'b0;
        cycle();
        n_chk++;
        if (sal_sh_r !== {1'b0, b}) begin
            n_err++;
            $display("FAIL load got=%b exp=%b", sal_sh_r, {1'b0, b});
        end
    endtask

    task automatic test_held();
        load(3'd7);
        init_sh_r = 1'b1;
        for (int c = 0; c < 20; c++) begin
            cycle();
            n_chk++;
            if (sal_sh_r !== 4'b0011) begin
                n_err++;
                $display("FAIL held c=%0d got=%b exp=%b", c, sal_sh_r, 4'b0011);
            end
        end
        init_sh_r = 1'b0;
        cycle();
    endtask

    task automatic test_back_to_back();
        load(3'd6);
        init_sh_r = 1'b1; cycle();
        n_chk++;
        if (sal_sh_r !== 4'b0011) begin
            n_err++; $display("FAIL b2b_first got=%b exp=%b", sal_sh_r, 4'b0011);
        end
        init_sh_r = 1'b0; cycle();
        init_sh_r = 1'b1; cycle();
        n_chk++;
        if (sal_sh_r !== 4'b0001) begin
            n_err++; $display("FAIL b2b_second got=%b exp=%b", sal_sh_r, 4'b0001);
        end
        init_sh_r = 1'b0; cycle();
        n_chk++;
        if (sal_sh_r !== 4'b0001) begin
            n_err++; $display("FAIL b2b_hold got=%b exp=%b", sal_sh_r, 4'b0001);
        end
        // Strobe pulse that never overlaps a rising edge: no shift
        load(3'd6);
        #0.2 init_sh_r = 1'b1;
        #0.5 init_sh_r = 1'b0;
        cycle();
        cycle();
        n_chk++;
        if (sal_sh_r !== 4'b0110) begin
            n_err++; $display("FAIL short_strobe got=%b exp=%b", sal_sh_r, 4'b0110);
        end
    endtask

    task automatic test_reset_mid();
        load(3'd5);
        for (int k = 0; k < 2; k++) begin
            init_sh_r = 1'b1; cycle();
            init_sh_r = 1'b0; cycle();
        end
        n_chk++;
        if (sal_sh_r !== 4'b0001) begin
            n_err++; $display("FAIL mid_two_shifts got=%b exp=%b", sal_sh_r, 4'b0001);
        end
        portB = 3'd3; rst = 1'b1; cycle();
        rst = 1'b0;
        n_chk++;
        if (sal_sh_r !== 4'b0011) begin
            n_err++; $display("FAIL mid_reload got=%b exp=%b", sal_sh_r, 4'b0011);
        end
        // Reset together with a rising strobe: load wins
        portB = 3'd5; rst = 1'b1; init_sh_r = 1'b1; cycle();
        n_chk++;
        if (sal_sh_r !== 4'b0101) begin
            n_err++; $display("FAIL rst_vs_strobe got=%b exp=%b", sal_sh_r, 4'b0101);
        end
        // Strobe still high at reset release: no shift
        rst = 1'b0; cycle(); cycle();
        n_chk++;
        if (sal_sh_r !== 4'b0101) begin
            n_err++; $display("FAIL strobe_through_rst got=%b exp=%b", sal_sh_r, 4'b0101);
        end
        init_sh_r = 1'b0; cycle();
    endtask

    task automatic test_portb_change();
        load(3'd5);
        portB = 3'd2;
        for (int c = 0; c < 4; c++) begin
            cycle();
            n_chk++;
            if (sal_sh_r !== 4'b0101) begin
                n_err++; $display("FAIL portb_ignored c=%0d got=%b exp=%b", c, sal_sh_r, 4'b0101);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rst       = ($urandom_range(0, 9) == 0);
            portB     = 3'($urandom_range(0, 7));
            init_sh_r = 1'($urandom_range(0, 1));
            cycle();
            n_chk++;
            if (int'(sal_sh_r) != m_val || $isunknown(sal_sh_r)) begin
                n_err++;
                $display("FAIL random c=%0d got=%b exp=%0d", c, sal_sh_r, m_val);
            end
        end
    endtask

    initial begin
        n_err = 0; n_chk = 0;
        m_val = 0; m_prev_high = 1'b0;
        rst = 1'b1; portB = 3'd5; init_sh_r = 1'b0;
        test_reset();
        test_single_shifts();
        test_held();
        test_back_to_back();
        test_reset_mid();
        test_portb_change();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
